// File: rtl/piso_tx_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter.
package piso_tx_pkg;

    // Two-state transmitter FSM encoding.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Width of the bit counter needed to index every bit of a word.
    function automatic int CNT_W(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready load and serial handshakes.
// Words are shifted out one bit per accepted serial transfer, with the final
// bit of each word flagged on s_last. A new word can be accepted on the same
// cycle the final bit leaves, so back-to-back words stream without a bubble.
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             s_out,
    output logic             s_valid,
    output logic             s_last,
    input  logic             s_ready,
    output logic             busy
);

    localparam int             CW      = CNT_W(WIDTH);
    localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] sr, sr_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             s_out_n, s_valid_n, s_last_n;
    logic             xfer, accept;

    assign busy = s_valid;

    // Next-state logic: load a word, shift on a transfer, or return to idle after the last bit.
    always_comb begin
        state_n    = state;
        sr_n       = sr;
        cnt_n      = cnt;
        s_out_n    = s_out;
        s_valid_n  = s_valid;
        s_last_n   = s_last;
        load_ready = (state == ST_IDLE) || ((state == ST_SHIFT) && s_last && s_ready);
        xfer       = s_valid && s_ready;
        accept     = load_valid && load_ready;

        if (accept) begin
            state_n   = ST_SHIFT;
            sr_n      = d_in;
            cnt_n     = '0;
            s_out_n   = LSB_FIRST ? d_in[0] : d_in[WIDTH-1];
            s_valid_n = 1'b1;
            s_last_n  = 1'b0;
        end else if ((state == ST_SHIFT) && xfer) begin
            if (s_last) begin
                state_n   = ST_IDLE;
                sr_n      = '0;
                cnt_n     = '0;
                s_out_n   = 1'b0;
                s_valid_n = 1'b0;
                s_last_n  = 1'b0;
            end else begin
                sr_n     = LSB_FIRST ? {1'b0, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], 1'b0};
                cnt_n    = cnt + 1'b1;
                s_out_n  = LSB_FIRST ? sr[1] : sr[WIDTH-2];
                s_last_n = ((cnt + 1'b1) == CNT_MAX);
            end
        end
    end

    // State, shift register, counter and serial outputs, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            sr      <= '0;
            cnt     <= '0;
            s_out   <= 1'b0;
            s_valid <= 1'b0;
            s_last  <= 1'b0;
        end else begin
            state   <= state_n;
            sr      <= sr_n;
            cnt     <= cnt_n;
            s_out   <= s_out_n;
            s_valid <= s_valid_n;
            s_last  <= s_last_n;
        end
    end

endmodule
